// File: rtl/cpu1_control_if.sv
// Memory request/response port between the control FSM (master) and memory (slave).
interface cpu1_control_if;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_wmask;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  modport master (output mem_read, mem_write, mem_wmask, input mem_resp, mem_rdata);
  modport slave  (input mem_read, mem_write, mem_wmask, output mem_resp, mem_rdata);
endinterface

// File: rtl/cpu1_control.sv
// Multi-cycle RV32I control FSM: fetches into IR, decodes, and drives the
// per-slice selects/immediates that fan out unchanged to the 32-slice datapath.
module cpu1_control (
  input  logic         clk,
  input  logic         rst,
  cpu1_control_if.master mem,
  output logic [31:0]  rs1_sel,
  output logic [31:0]  rs2_sel,
  output logic [31:0]  rd_sel,
  output logic [31:0]  imm,
  output logic         alu_mux_1_sel,
  output logic         alu_mux_2_sel,
  output logic         alu_inv_rs2,
  output logic         alu_cin,
  output logic [1:0]   alu_op,
  output logic         shift_dir,
  output logic         shift_arith,
  output logic [4:0]   shift_amount,
  output logic         shift_src_rs2,
  output logic         cmp_mux_sel,
  output logic         cmp_signed,
  input  logic         cmp_eq,
  input  logic         cmp_lt,
  output logic [2:0]   rd_mux_sel,
  output logic         lb,
  output logic         lh,
  output logic         lw,
  output logic         lbu,
  output logic         lhu,
  input  logic [1:0]   addr_lo,
  output logic         pc_load,
  output logic         pc_mux_sel,
  output logic         halt
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  // Operand/select bundle driven DECODE through WB, zero elsewhere.
  typedef struct packed {
    logic [31:0] rs1_sel;
    logic [31:0] rs2_sel;
    logic [31:0] imm;
    logic        alu_mux_1_sel;
    logic        alu_mux_2_sel;
    logic        alu_inv_rs2;
    logic        alu_cin;
    logic [1:0]  alu_op;
    logic        shift_dir;
    logic        shift_arith;
    logic [4:0]  shift_amount;
    logic        shift_src_rs2;
    logic        cmp_mux_sel;
    logic        cmp_signed;
    logic [2:0]  rd_mux_sel;
  } ctl_t;

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        taken_q, taken_d;
  logic        halt_q, halt_d;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rs1, rs2, rd;

  assign opc = ir_q[6:0];
  assign rd  = ir_q[11:7];
  assign f3  = ir_q[14:12];
  assign rs1 = ir_q[19:15];
  assign rs2 = ir_q[24:20];
  assign f7  = ir_q[31:25];

  function automatic logic [31:0] onehot(input logic [4:0] r);
    onehot = (r == 5'd0) ? 32'd0 : (32'd1 << r);
  endfunction

  ctl_t dec, ctl;
  logic legal, writes_rd, uses_rs1, uses_rs2;
  logic is_load, is_store, is_branch, is_jump, is_imm;
  logic br_cond;

  always_comb begin
    dec       = '0;
    legal     = 1'b0;
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_imm    = (opc == OPC_OPIMM);
    case (opc)
      OPC_LUI: begin
        legal = 1'b1; writes_rd = 1'b1;
        dec.imm = {ir_q[31:12], 12'd0};
        dec.rd_mux_sel = 3'd5;
      end
      OPC_AUIPC: begin
        legal = 1'b1; writes_rd = 1'b1;
        dec.imm = {ir_q[31:12], 12'd0};
        dec.alu_mux_1_sel = 1'b1; dec.alu_mux_2_sel = 1'b1;
      end
      OPC_JAL: begin
        legal = 1'b1; writes_rd = 1'b1; is_jump = 1'b1;
        dec.imm = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
        dec.alu_mux_1_sel = 1'b1; dec.alu_mux_2_sel = 1'b1;
        dec.rd_mux_sel = 3'd4;
      end
      OPC_JALR: begin
        legal = (f3 == 3'b000); writes_rd = 1'b1; is_jump = 1'b1; uses_rs1 = 1'b1;
        dec.imm = {{20{ir_q[31]}}, ir_q[31:20]};
        dec.alu_mux_2_sel = 1'b1;
        dec.rd_mux_sel = 3'd4;
      end
      OPC_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011);
        is_branch = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.imm = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        dec.alu_mux_1_sel = 1'b1; dec.alu_mux_2_sel = 1'b1;
        dec.cmp_signed = (f3[2:1] == 2'b10);
      end
      OPC_LOAD: begin
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        is_load = 1'b1; writes_rd = 1'b1; uses_rs1 = 1'b1;
        dec.imm = {{20{ir_q[31]}}, ir_q[31:20]};
        dec.alu_mux_2_sel = 1'b1;
        dec.rd_mux_sel = 3'd3;
      end
      OPC_STORE: begin
        legal = !f3[2] && (f3 != 3'b011);
        is_store = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        dec.imm = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        dec.alu_mux_2_sel = 1'b1;
      end
      OPC_OPIMM, OPC_OP: begin
        writes_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = !is_imm;
        if (is_imm)
          legal = (f3 == 3'b001) ? (f7 == 7'h00) :
                  (f3 == 3'b101) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        else
          legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101));
        dec.alu_mux_2_sel = is_imm;
        dec.imm = is_imm ? {{20{ir_q[31]}}, ir_q[31:20]} : 32'd0;
        case (f3)
          3'b000: begin
            dec.alu_inv_rs2 = !is_imm && f7[5];
            dec.alu_cin     = !is_imm && f7[5];
          end
          3'b001, 3'b101: begin
            dec.shift_dir     = f3[2];
            dec.shift_arith   = f3[2] && f7[5];
            dec.shift_src_rs2 = !is_imm;
            dec.rd_mux_sel    = 3'd1;
            if (is_imm) begin
              dec.imm          = {27'd0, ir_q[24:20]};
              dec.shift_amount = ir_q[24:20];
            end
          end
          3'b010, 3'b011: begin
            dec.alu_inv_rs2 = 1'b1;
            dec.alu_cin     = 1'b1;
            dec.cmp_signed  = !f3[0];
            dec.cmp_mux_sel = is_imm;
            dec.rd_mux_sel  = 3'd2;
          end
          3'b100:  dec.alu_op = 2'b01;
          3'b110:  dec.alu_op = 2'b10;
          default: dec.alu_op = 2'b11;
        endcase
      end
      default: legal = 1'b0;
    endcase
    dec.rs1_sel = uses_rs1 ? onehot(rs1) : 32'd0;
    dec.rs2_sel = uses_rs2 ? onehot(rs2) : 32'd0;
  end

  always_comb begin
    case (f3)
      3'b000:         br_cond = cmp_eq;
      3'b001:         br_cond = !cmp_eq;
      3'b100, 3'b110: br_cond = cmp_lt;
      3'b101, 3'b111: br_cond = !cmp_lt;
      default:        br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    taken_d = taken_q;
    halt_d  = halt_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem.mem_resp) begin
          ir_d    = mem.mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) state_d = S_EXEC;
        else begin
          state_d = S_TRAP;
          halt_d  = 1'b1;
        end
      end
      S_EXEC: begin
        taken_d = is_branch && br_cond;
        state_d = (is_load || is_store) ? S_MEM : S_WB;
      end
      S_MEM:    if (mem.mem_resp) state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
      ir_q    <= 32'd0;
      taken_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      taken_q <= taken_d;
      halt_q  <= halt_d;
    end
  end

  logic       active;
  logic       mem_read_o, mem_write_o;
  logic [3:0] wmask_o;
  logic [4:0] ld_o;

  assign active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                  (state_q == S_MEM)    || (state_q == S_WB);

  always_comb begin
    ctl         = active ? dec : '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    wmask_o     = 4'd0;
    ld_o        = 5'd0;
    rd_sel      = 32'd0;
    pc_load     = 1'b0;
    pc_mux_sel  = 1'b0;
    case (state_q)
      S_FETCH: mem_read_o = 1'b1;
      S_MEM: begin
        mem_read_o  = is_load;
        mem_write_o = is_store;
        if (is_store) begin
          case (f3[1:0])
            2'b00:   wmask_o = 4'b0001 << addr_lo;
            2'b01:   wmask_o = 4'b0011 << addr_lo;
            default: wmask_o = 4'b1111;
          endcase
        end
      end
      S_WB: begin
        pc_load    = 1'b1;
        pc_mux_sel = is_jump || (is_branch && taken_q);
        rd_sel     = writes_rd ? onehot(rd) : 32'd0;
      end
      default: ;
    endcase
    // Load-type one-hot (lb,lh,lw,lbu,lhu) only while the load result is in flight.
    if (is_load && (state_q == S_MEM || state_q == S_WB)) begin
      case (f3)
        3'b000:  ld_o = 5'b10000;
        3'b001:  ld_o = 5'b01000;
        3'b010:  ld_o = 5'b00100;
        3'b100:  ld_o = 5'b00010;
        3'b101:  ld_o = 5'b00001;
        default: ld_o = 5'b00000;
      endcase
    end
  end

  assign mem.mem_read  = mem_read_o;
  assign mem.mem_write = mem_write_o;
  assign mem.mem_wmask = wmask_o;
  assign {lb, lh, lw, lbu, lhu} = ld_o;

  assign rs1_sel       = ctl.rs1_sel;
  assign rs2_sel       = ctl.rs2_sel;
  assign imm           = ctl.imm;
  assign alu_mux_1_sel = ctl.alu_mux_1_sel;
  assign alu_mux_2_sel = ctl.alu_mux_2_sel;
  assign alu_inv_rs2   = ctl.alu_inv_rs2;
  assign alu_cin       = ctl.alu_cin;
  assign alu_op        = ctl.alu_op;
  assign shift_dir     = ctl.shift_dir;
  assign shift_arith   = ctl.shift_arith;
  assign shift_amount  = ctl.shift_amount;
  assign shift_src_rs2 = ctl.shift_src_rs2;
  assign cmp_mux_sel   = ctl.cmp_mux_sel;
  assign cmp_signed    = ctl.cmp_signed;
  assign rd_mux_sel    = ctl.rd_mux_sel;
  assign halt          = halt_q;

endmodule

// File: tb/tb_cpu1_control.sv
// Directed bench for cpu1_control: hand-encoded instructions, step-by-step state checks.
module tb_cpu1_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cpu1_control_if mif();

  logic [31:0] rs1_sel, rs2_sel, rd_sel, imm;
  logic        alu_mux_1_sel, alu_mux_2_sel, alu_inv_rs2, alu_cin;
  logic [1:0]  alu_op;
  logic        shift_dir, shift_arith, shift_src_rs2, cmp_mux_sel, cmp_signed;
  logic [4:0]  shift_amount;
  logic        cmp_eq, cmp_lt;
  logic [2:0]  rd_mux_sel;
  logic        lb, lh, lw, lbu, lhu;
  logic [1:0]  addr_lo;
  logic        pc_load, pc_mux_sel, halt;
  logic [4:0]  ldv;
  assign ldv = {lb, lh, lw, lbu, lhu};

  cpu1_control dut (
    .clk(clk), .rst(rst), .mem(mif),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .rd_sel(rd_sel), .imm(imm),
    .alu_mux_1_sel(alu_mux_1_sel), .alu_mux_2_sel(alu_mux_2_sel),
    .alu_inv_rs2(alu_inv_rs2), .alu_cin(alu_cin), .alu_op(alu_op),
    .shift_dir(shift_dir), .shift_arith(shift_arith), .shift_amount(shift_amount),
    .shift_src_rs2(shift_src_rs2), .cmp_mux_sel(cmp_mux_sel), .cmp_signed(cmp_signed),
    .cmp_eq(cmp_eq), .cmp_lt(cmp_lt), .rd_mux_sel(rd_mux_sel),
    .lb(lb), .lh(lh), .lw(lw), .lbu(lbu), .lhu(lhu), .addr_lo(addr_lo),
    .pc_load(pc_load), .pc_mux_sel(pc_mux_sel), .halt(halt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait instruction fetch; leaves the DUT in DECODE.
  task automatic fetch(input logic [31:0] w);
    chk("fetch_mem_read", {31'd0, mif.mem_read}, 32'd1);
    mif.mem_resp  = 1'b1;
    mif.mem_rdata = w;
    tick();
    mif.mem_resp  = 1'b0;
  endtask

  initial begin
    mif.mem_resp = 1'b0; mif.mem_rdata = 32'd0;
    cmp_eq = 1'b0; cmp_lt = 1'b0; addr_lo = 2'd0;
    repeat (2) tick();
    chk("rst_mem_read", {31'd0, mif.mem_read}, 32'd0);
    chk("rst_halt",     {31'd0, halt}, 32'd0);
    chk("rst_pc_load",  {31'd0, pc_load}, 32'd0);
    chk("rst_imm",      imm, 32'd0);

    // stale resp during RESET must not be consumed
    mif.mem_resp = 1'b1;
    rst = 1'b0;
    chk("reset_state_read", {31'd0, mif.mem_read}, 32'd0);
    tick();

    // ADDI x1, x0, 5
    fetch(32'h00500093);
    chk("addi_dec_imm",  imm, 32'd5);
    chk("addi_dec_read", {31'd0, mif.mem_read}, 32'd0);
    chk("addi_dec_rs1",  rs1_sel, 32'd0);
    tick(); tick();
    chk("addi_wb_rd_sel",  rd_sel, 32'h2);
    chk("addi_wb_rd_mux",  {29'd0, rd_mux_sel}, 32'd0);
    chk("addi_wb_mux2",    {31'd0, alu_mux_2_sel}, 32'd1);
    chk("addi_wb_imm",     imm, 32'd5);
    chk("addi_wb_pc_load", {31'd0, pc_load}, 32'd1);
    chk("addi_wb_pc_mux",  {31'd0, pc_mux_sel}, 32'd0);
    tick();

    // BEQ x1, x2, -8 taken
    fetch(32'hFE208CE3);
    chk("beq_rs1", rs1_sel, 32'h2);
    chk("beq_rs2", rs2_sel, 32'h4);
    chk("beq_mux1", {31'd0, alu_mux_1_sel}, 32'd1);
    cmp_eq = 1'b1;
    tick(); tick();
    chk("beq_t_pc_mux", {31'd0, pc_mux_sel}, 32'd1);
    chk("beq_t_imm",    imm, 32'hFFFFFFF8);
    chk("beq_t_rd_sel", rd_sel, 32'd0);
    tick();
    // not taken
    cmp_eq = 1'b0;
    fetch(32'hFE208CE3);
    tick(); tick();
    chk("beq_nt_pc_mux",  {31'd0, pc_mux_sel}, 32'd0);
    chk("beq_nt_pc_load", {31'd0, pc_load}, 32'd1);
    tick();

    // SUB x3, x1, x2
    fetch(32'h402081B3);
    chk("sub_inv",  {31'd0, alu_inv_rs2}, 32'd1);
    chk("sub_cin",  {31'd0, alu_cin}, 32'd1);
    chk("sub_mux2", {31'd0, alu_mux_2_sel}, 32'd0);
    chk("sub_rs2",  rs2_sel, 32'h4);
    tick(); tick();
    chk("sub_wb_rd_sel", rd_sel, 32'h8);
    tick();

    // SB x2, 0(x1), addr_lo=2, resp delayed 3 cycles
    addr_lo = 2'd2;
    fetch(32'h00208023);
    tick(); tick();
    chk("sb_mem_write", {31'd0, mif.mem_write}, 32'd1);
    chk("sb_wmask",     {28'd0, mif.mem_wmask}, 32'h4);
    chk("sb_mem_read",  {31'd0, mif.mem_read}, 32'd0);
    chk("sb_rd_sel",    rd_sel, 32'd0);
    tick(); tick(); tick();
    chk("sb_mem4_write", {31'd0, mif.mem_write}, 32'd1);
    mif.mem_resp = 1'b1;
    tick();
    mif.mem_resp = 1'b0;
    chk("sb_wb_write",   {31'd0, mif.mem_write}, 32'd0);
    chk("sb_wb_pc_load", {31'd0, pc_load}, 32'd1);
    tick();
    chk("sb_next_pc_load", {31'd0, pc_load}, 32'd0);

    // LHU x5, 0(x6) with a one-cycle fetch wait and two-cycle data wait
    chk("lhu_fetch_wait0", {31'd0, mif.mem_read}, 32'd1);
    tick();
    fetch(32'h00035283);
    tick();
    chk("lhu_exec_ld", {27'd0, ldv}, 32'd0);
    tick();
    chk("lhu_mem_read", {31'd0, mif.mem_read}, 32'd1);
    chk("lhu_mem_ld",   {27'd0, ldv}, 32'h1);
    tick();
    chk("lhu_mem_read_hold", {31'd0, mif.mem_read}, 32'd1);
    mif.mem_resp = 1'b1;
    tick();
    mif.mem_resp = 1'b0;
    chk("lhu_wb_rd_mux", {29'd0, rd_mux_sel}, 32'd3);
    chk("lhu_wb_rd_sel", rd_sel, 32'h20);
    chk("lhu_wb_ld",     {27'd0, ldv}, 32'h1);
    chk("lhu_wb_read",   {31'd0, mif.mem_read}, 32'd0);
    tick();

    // reset while FETCH is waiting
    chk("rstf_read_before", {31'd0, mif.mem_read}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstf_read_drop", {31'd0, mif.mem_read}, 32'd0);
    mif.mem_resp = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstf_reset_state", {31'd0, mif.mem_read}, 32'd0);
    tick();

    // illegal word traps
    fetch(32'h00000000);
    chk("ill_dec_halt", {31'd0, halt}, 32'd0);
    tick();
    chk("ill_trap_halt", {31'd0, halt}, 32'd1);
    chk("ill_trap_read", {31'd0, mif.mem_read}, 32'd0);
    tick(); tick();
    chk("ill_stay_halt", {31'd0, halt}, 32'd1);
    chk("ill_stay_read", {31'd0, mif.mem_read}, 32'd0);
    chk("ill_stay_pcld", {31'd0, pc_load}, 32'd0);
    rst = 1'b1;
    #1;
    chk("ill_rst_halt", {31'd0, halt}, 32'd0);
    tick();
    rst = 1'b0;
    chk("ill_rel_read", {31'd0, mif.mem_read}, 32'd0);
    tick();
    chk("ill_refetch", {31'd0, mif.mem_read}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
